// File: rtl/serial_addsub_pkt_if.sv
// Bit-serial add/subtract packet bus: LSB-first operand beats in, per-packet result out.
interface serial_addsub_pkt_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 6
);
  logic             vld;
  logic             a;
  logic             b;
  logic             sub;
  logic             last;
  logic [WIDTH-1:0] sum;
  logic             res_vld;
  logic             carry_out;
  logic             too_long;
  logic [CNT_W-1:0] len;

  modport master (
    output vld, a, b, sub, last,
    input  sum, res_vld, carry_out, too_long, len
  );

  modport slave (
    input  vld, a, b, sub, last,
    output sum, res_vld, carry_out, too_long, len
  );
endinterface

// File: rtl/serial_addsub_pkt.sv
// Bit-serial adder/subtractor: accumulates one sum bit per valid beat and
// publishes the packet result, carry, length and overflow flag after the last beat.
module serial_addsub_pkt #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 6
) (
  input logic               clk,
  input logic               rst,
  serial_addsub_pkt_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  typedef enum logic {IDLE, ACC} state_e;

  state_e           state_q;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q;
  logic             res_vld_q;
  logic             carry_out_q;
  logic             too_long_q;
  logic [CNT_W-1:0] len_q;

  logic             first;
  logic             cin;
  logic             b_eff;
  logic             sbit;
  logic [CNT_W-1:0] idx;

  // One full-adder step; the first beat of a packet restarts from a cleared working register.
  always_comb begin
    first   = (state_q == IDLE);
    mode_d  = first ? bus.sub : mode_q;
    cin     = first ? bus.sub : carry_q;
    b_eff   = bus.b ^ mode_d;
    sbit    = bus.a ^ b_eff ^ cin;
    carry_d = (bus.a & b_eff) | (bus.a & cin) | (b_eff & cin);
    idx     = first ? '0 : cnt_q;
    work_d  = first ? '0 : work_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == CNT_W'(i)) work_d[i] = sbit;
    end
    if (first)                 cnt_d = CNT_W'(1);
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CNT_W'(1);
  end

  // State machine plus datapath registers; idle cycles (vld=0) only drop res_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      work_q      <= '0;
      sum_q       <= '0;
      res_vld_q   <= 1'b0;
      carry_out_q <= 1'b0;
      too_long_q  <= 1'b0;
      len_q       <= '0;
    end else begin
      res_vld_q <= 1'b0;
      if (bus.vld) begin
        mode_q  <= mode_d;
        carry_q <= carry_d;
        cnt_q   <= cnt_d;
        work_q  <= work_d;
        if (bus.last) begin
          state_q     <= IDLE;
          sum_q       <= work_d;
          carry_out_q <= carry_d;
          len_q       <= cnt_d;
          too_long_q  <= (cnt_d > WIDTH_C);
          res_vld_q   <= 1'b1;
        end else begin
          state_q <= ACC;
        end
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.res_vld   = res_vld_q;
  assign bus.carry_out = carry_out_q;
  assign bus.too_long  = too_long_q;
  assign bus.len       = len_q;

endmodule
